// File: rtl/uart_frame_tx.sv
// -----------------------------------------------------------------------------
// uart_frame_tx
//   Serial UART transmitter with a one-entry holding register in front of the
//   shift register, so a second word can be queued while a frame is on the
//   line and sent back-to-back with no idle gap.
//
//   Frame: start (0), DBITS data bits LSB first, [parity], stop (1).
//   Every bit except stop lasts 16 oversampling ticks; stop lasts SB_TICK
//   ticks. One tick = BR_LIMIT clocks.
//
// Optional feature (compile-time macro UART_FRAME_TX_PARITY_EN):
//   defined   -> a parity bit is sent between the data bits and the stop bit.
//                Even parity by default, odd when PARITY_ODD=1.
//   undefined -> no parity state or logic.
//
// Ports
//   clk_100MHz : system clock, all logic on the rising edge
//   reset      : asynchronous, active-high reset
//   tx_data    : word to transmit
//   tx_valid   : tx_data is valid; taken on an edge where tx_ready is high
//   tx_ready   : holding register is empty
//   tx         : registered serial output, idles high
//   tx_busy    : registered, high whenever a frame is in progress
//   tx_done    : one-cycle pulse in the final clock of each stop bit
// -----------------------------------------------------------------------------
module uart_frame_tx #(
  parameter int DBITS      = 8,
  parameter int SB_TICK    = 16,
  parameter int BR_LIMIT   = 651,
  parameter int BR_BITS    = 10,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic [DBITS-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx,
  output logic             tx_busy,
  output logic             tx_done
);

  // Per-state tick counter must reach both 15 and SB_TICK-1.
  localparam int STW = $clog2(((SB_TICK > 16) ? SB_TICK : 16) + 1);
  localparam int NW  = $clog2(DBITS + 1);

  localparam logic [BR_BITS-1:0] CNT_LAST    = BR_BITS'(BR_LIMIT - 1);
  localparam logic [STW-1:0]     S_LAST_BIT  = STW'(15);
  localparam logic [STW-1:0]     S_LAST_STOP = STW'(SB_TICK - 1);
  localparam logic [NW-1:0]      N_LAST      = NW'(DBITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_FRAME_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [BR_BITS-1:0]   cnt_q, cnt_d;       // clocks within the current tick
  logic [STW-1:0]       s_q, s_d;           // ticks within the current bit
  logic [NW-1:0]        n_q, n_d;           // data bit index
  logic [DBITS-1:0]     b_q, b_d;           // shifter
  logic [DBITS-1:0]     hold_q, hold_d;     // holding register
  logic                 hold_full_q, hold_full_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
`ifdef UART_FRAME_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  logic tick;
  logic load;   // move holding register into shifter and (re)enter START
  logic done;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    n_d         = n_q;
    b_d         = b_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;
    done        = 1'b0;
`ifdef UART_FRAME_TX_PARITY_EN
    par_d       = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (hold_full_q) load = 1'b1;
      end
      START: begin
        if (tick) begin
          if (s_q == S_LAST_BIT) begin
            state_d = DATA;
            s_d     = '0;
            n_d     = '0;
          end else begin
            s_d = s_q + STW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == S_LAST_BIT) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
`ifdef UART_FRAME_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + STW'(1);
          end
        end
      end
`ifdef UART_FRAME_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s_q == S_LAST_BIT) begin
            state_d = STOP;
            s_d     = '0;
          end else begin
            s_d = s_q + STW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s_q == S_LAST_STOP) begin
            done = 1'b1;
            s_d  = '0;
            // A queued word follows immediately with no idle gap.
            if (hold_full_q) load = 1'b1;
            else             state_d = IDLE;
          end else begin
            s_d = s_q + STW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // load requires hold_full, which blocks an accept, so the two never
    // collide on the holding register.
    if (load) begin
      state_d     = START;
      s_d         = '0;
      n_d         = '0;
      b_d         = hold_q;
      hold_full_d = 1'b0;
`ifdef UART_FRAME_TX_PARITY_EN
      // Captured at load time because the shifter is consumed during DATA.
      par_d       = (^hold_q) ^ (PARITY_ODD != 0);
`endif
    end else if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    // Clearing on START entry makes every start bit a full 16 ticks even when
    // leaving IDLE at an arbitrary phase of the free-running counter.
    cnt_d = (load || tick) ? '0 : cnt_q + BR_BITS'(1);

    // tx is registered, so drive the level belonging to the next state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
`ifdef UART_FRAME_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      s_q         <= '0;
      n_q         <= '0;
      b_q         <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
`ifdef UART_FRAME_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s_q         <= s_d;
      n_q         <= n_d;
      b_q         <= b_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
`ifdef UART_FRAME_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

`ifndef UART_FRAME_TX_PARITY_EN
  // Parity sense has no meaning when no parity bit is transmitted.
  if (PARITY_ODD != 0) begin : g_parity_sense_ignored
  end
`endif

  assign tx_ready = ~hold_full_q;
  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done;   // decoded from registers only; low in reset (IDLE)

endmodule

// File: doc/uart_frame_tx.md
UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 Parameters SHALL be one per line as follows.
- DBITS, 8, data bits per word.
- SB_TICK, 16, stop-bit length in oversampling ticks.
- BR_LIMIT, 651, clocks per oversampling tick (16x baud).
- BR_BITS, 10, tick counter width.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored unless the parity macro is defined.

REQ-002 Ports SHALL be one per line as follows.
- clk_100MHz, input, 1, single system clock; all logic is rising-edge.
- reset, input, 1, asynchronous, active-high reset.
- tx_data, input, DBITS, word to transmit.
- tx_valid, input, 1, tx_data is valid.
- tx_ready, output, 1, holding register is empty; the block can accept a word.
- tx, output, 1, registered serial output; idles high.
- tx_busy, output, 1, a frame is in progress (state not IDLE).
- tx_done, output, 1, one-cycle pulse at the end of each frame's stop bit.

Function
REQ-003 Tick counter: count 0..BR_LIMIT-1 and wrap; tick SHALL be high in the cycle where count == BR_LIMIT-1.
REQ-004 The tick counter SHALL be cleared on every entry to START, so each start bit is exactly 16*BR_LIMIT clocks.
REQ-005 Handshake: a word SHALL be accepted on any rising edge where tx_valid && tx_ready.
- The accepted word loads a one-entry holding register.
- tx_ready = ~hold_full.
REQ-006 While tx_ready is low, tx_data and tx_valid SHALL be ignored; no word is dropped or overwritten.
REQ-007 The FSM SHALL have states IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-008 IDLE with hold_full: on the next edge the FSM SHALL enter START, move the holding register into the shifter, and clear hold_full.
- Consequence: tx falls one clock after the accept edge.
REQ-009 START drives 0 for 16 ticks.
REQ-010 DATA drives the shifter LSB first, 16 ticks per bit, for DBITS bits.
REQ-011 PARITY drives the parity bit for 16 ticks.
REQ-012 STOP drives 1 for SB_TICK ticks.
REQ-013 On the final STOP tick, tx_done SHALL pulse for exactly one cycle and the FSM SHALL take one of two paths.
- hold_full: go directly to START (no idle gap) and load the next word.
- Otherwise: go to IDLE.
REQ-014 A word accepted during a frame SHALL wait in the holding register.
- tx_ready becomes high again on the edge after that word moves into the shifter.
REQ-015 Tick and bit counters SHALL be sized to hold 16, SB_TICK and DBITS without overflow.
REQ-016 tx_busy SHALL be registered and high in every state except IDLE.

Reset
REQ-017 While reset is high, the block SHALL hold these values, independent of the clock:
- tx=1, tx_ready=1, tx_busy=0, tx_done=0.
- state=IDLE; all counters 0; hold_full=0.
REQ-018 Reset asserted mid-frame SHALL abort the frame and discard both shifter and holding contents.
- tx returns high immediately.
REQ-019 After reset deasserts, the first accepted word SHALL transmit a complete, correct frame.

Configuration
REQ-020 Macro UART_FRAME_TX_PARITY_EN SHALL control the parity feature.
- Defined: the PARITY state is inserted between DATA and STOP. Its bit is XOR of the data bits (even parity), inverted when PARITY_ODD=1.
- Undefined: no PARITY state or logic; the frame is START, DBITS data bits, STOP only.

Verification (BR_LIMIT=4, so 1 bit = 64 clocks; DBITS=8; SB_TICK=16)
REQ-021 Reset: assert reset mid-operation.
- Required: tx=1, tx_ready=1, tx_busy=0, tx_done=0 with no clock edge needed.
REQ-022 Single frame (no macro): send 0x55.
- tx low 64 clocks starting one clock after accept.
- Then 1,0,1,0,1,0,1,0, each 64 clocks.
- Then high 64 clocks; tx_done pulses in the frame's final clock; frame is 640 clocks.
REQ-023 Back-to-back: send 0xA3, then offer 0x0F while tx_ready=0.
- tx_ready rises after 0xA3 enters the shifter; 0x0F is accepted.
- 0x0F's start bit follows 0xA3's stop bit with zero gap; total 1280 clocks; two tx_done pulses.
REQ-024 Backpressure: hold tx_valid=1 with 0xFF while the holding register is full.
- No extra accept occurs; exactly the expected frames appear on tx.
REQ-025 Parity (macro defined): send 0x07.
- PARITY_ODD=0: parity bit 1. PARITY_ODD=1: parity bit 0.
- Frame is 704 clocks.
REQ-026 Abort: assert reset during data bit 3 of 0xC4 with a word queued.
- tx=1 immediately; both words lost.
- After release, sending 0x3C produces one correct frame.
